debounced_input: RTL and testbench
==================================

Name: debounced_input

Overview:
- Consumes the synchronized bit from the two-flop clock synchronizer and produces a glitch-free level with single-cycle edge strobes.
- Used for buttons, switches and other slow external strobes.
- Sits directly downstream of the synchronizer, in the same clock domain; bit_in is already synchronous to clk and is never re-synchronized here.

Parameters:
- STABLE_CYCLES, 16: consecutive differing samples required before level flips; legal range 1 to 65535.
- RESET_LEVEL, 1'b0: value of level during and after reset.
- HOLD_CYCLES, 1000: cycles level must stay high before hold asserts; used only with the optional feature; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock, same domain as the synchronizer output
- reset_n  input  1  asynchronous, active-low reset
- bit_in  input  1  synchronized raw input (synchronizer bit_out)
- level  output  1  debounced level (registered)
- rise  output  1  one-cycle strobe, asserted in the cycle level first reads 1
- fall  output  1  one-cycle strobe, asserted in the cycle level first reads 0
- hold  output  1  level has been high ≥ HOLD_CYCLES (optional feature)

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - While reset_n = 0: level = RESET_LEVEL; rise = fall = hold = 0; counters = 0; state = STABLE_LOW or STABLE_HIGH per RESET_LEVEL.
  - Deassertion takes effect at the next clk edge. Reset mid-confirm discards the partial count.
- States: STABLE_LOW, CONFIRM_HIGH, STABLE_HIGH, CONFIRM_LOW. Counter width is $clog2(STABLE_CYCLES+1).
- STABLE_x, sample == level: stay; counter = 0.
- STABLE_x, sample != level:
  - If STABLE_CYCLES == 1, flip immediately (see flip rule).
  - Otherwise go to CONFIRM_y; counter = 1.
- CONFIRM_y, sample != level:
  - If counter == STABLE_CYCLES-1, flip.
  - Otherwise counter increments.
- CONFIRM_y, sample == level: return to STABLE_x; counter = 0. A glitch shorter than STABLE_CYCLES produces no output change.
- Flip: at the same edge, level <= sample, state goes to STABLE of the new level, counter = 0, and rise or fall is registered high.
- Strobes: high for exactly one cycle, the first cycle in which the new level is visible. rise and fall are never high together.
- Latency: level changes at the edge that samples the STABLE_CYCLES-th consecutive differing value. With STABLE_CYCLES = 1, level is a one-cycle registered copy of bit_in.
- Counter never exceeds STABLE_CYCLES-1 and never wraps.
- A continuously toggling input every cycle holds level forever, with no strobes.

Optional Feature:
- Macro: DEBOUNCED_INPUT_HOLD_EN.
- Defined:
  - A hold counter (width $clog2(HOLD_CYCLES+1)) clears whenever level == 0 or a rise strobe occurs.
  - It increments each cycle while level == 1 and saturates at HOLD_CYCLES.
  - hold = 1 while counter == HOLD_CYCLES; hold clears in the same cycle fall asserts.
- Undefined: hold port remains present, tied to 0; no hold counter logic.

Decomposition:
- Package debounced_input_pkg:
  - state enum typedef (2-bit) for the four states;
  - constant function for counter width (clog2 with minimum 1).
- Sub-module: none required.
  - Optional hold logic is a small saturating counter, kept inline under the macro guard.

Test Plan:
- Reset then idle, STABLE_CYCLES=4, RESET_LEVEL=0: bit_in=0, release reset_n -> level=0, rise=fall=hold=0 for 20 cycles.
- Clean press: bit_in 0->1 held 10 cycles -> level=1 at the 4th sampling edge after the change; rise=1 for exactly that cycle; fall stays 0.
- Glitch rejection: bit_in high for 3 cycles then low -> level stays 0, no strobe; a subsequent 4-cycle high then flips level with a single rise.
- Release with bounce: from level=1, bit_in pattern 0,1,0,0,0,0 -> fall appears 4 edges after the final 0-run begins; exactly one fall.
- Reset mid-confirm: bit_in high 2 cycles, reset_n pulsed low mid-cycle -> outputs return to reset values immediately (asynchronously); after release, a full 4-sample run is needed to flip.
- DEBOUNCED_INPUT_HOLD_EN defined, HOLD_CYCLES=8: level high 8 cycles -> hold=1 on the 8th cycle after rise; bit_in low 4 cycles -> hold=0 in the same cycle as fall.

Source files
------------

// File: rtl/debounced_input_pkg.sv
// Shared types and helpers for the debounced_input block.
package debounced_input_pkg;

  // Debounce FSM: the STABLE_* state names the current level, CONFIRM_* the
  // level being confirmed.
  typedef enum logic [1:0] {
    ST_STABLE_LOW   = 2'd0,
    ST_CONFIRM_HIGH = 2'd1,
    ST_STABLE_HIGH  = 2'd2,
    ST_CONFIRM_LOW  = 2'd3
  } state_e;

  // Width of a counter that must hold 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounced_input.sv
// Debouncer for a synchronized slow input: a level flips only after
// STABLE_CYCLES consecutive differing samples, with one-cycle rise/fall strobes.
// Optional hold detect (level high for HOLD_CYCLES) is built when
// DEBOUNCED_INPUT_HOLD_EN is defined; otherwise hold is tied to 0.
module debounced_input
  import debounced_input_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   HOLD_CYCLES   = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int            CW        = cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam state_e        RST_STATE = RESET_LEVEL ? ST_STABLE_HIGH : ST_STABLE_LOW;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, rise_d, fall_d, flip;
  logic          differ;

  assign differ = (bit_in != level);

  // Next-state: track a run of differing samples, flip on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    flip    = 1'b0;
    case (state_q)
      ST_STABLE_LOW, ST_STABLE_HIGH: begin
        if (!differ) begin
          cnt_d = '0;
        end else if (STABLE_CYCLES == 1) begin
          flip = 1'b1;
        end else begin
          state_d = bit_in ? ST_CONFIRM_HIGH : ST_CONFIRM_LOW;
          cnt_d   = CW'(1);
        end
      end
      ST_CONFIRM_HIGH, ST_CONFIRM_LOW: begin
        if (!differ) begin
          // Run broken: glitch is dropped without touching the outputs.
          state_d = level ? ST_STABLE_HIGH : ST_STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          flip = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
    if (flip) begin
      level_d = bit_in;
      state_d = bit_in ? ST_STABLE_HIGH : ST_STABLE_LOW;
      cnt_d   = '0;
      rise_d  = bit_in;
      fall_d  = !bit_in;
    end
  end

  // State, run counter, level and strobes; reset discards any partial run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      level   <= RESET_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

`ifdef DEBOUNCED_INPUT_HOLD_EN
  localparam int            HW       = cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [HW-1:0] hcnt_q;

  // Saturating high-time counter; keyed off next-state values so it is 0 in
  // the rise cycle and drops in the same cycle fall asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hcnt_q <= '0;
    else if (!level_d || rise_d)
      hcnt_q <= '0;
    else if (hcnt_q != HOLD_MAX)
      hcnt_q <= hcnt_q + HW'(1);
  end

  assign hold = (hcnt_q == HOLD_MAX);
`else
  // Feature compiled out: constant 0 (HOLD_CYCLES is never negative).
  assign hold = (HOLD_CYCLES < 0);
`endif

endmodule

// File: tb/tb_debounced_input.sv
// Directed bench for debounced_input: STABLE_CYCLES=4 main instance plus a
// STABLE_CYCLES=1 instance checked against a one-cycle-delay model.
module tb_debounced_input;

`ifdef DEBOUNCED_INPUT_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  typedef struct {
    logic b;
    logic l, r, f, h;
  } vec_t;

  logic clk = 1'b0, reset_n = 1'b0, bit_in = 1'b0;
  logic level, rise, fall, hold;
  logic level1, rise1, fall1, hold1;
  int   tests = 0, fails = 0;
  logic m1 = 1'b0;
  int   h1 = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  debounced_input #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in),
    .level(level), .rise(rise), .fall(fall), .hold(hold)
  );

  debounced_input #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b0), .HOLD_CYCLES(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .bit_in(bit_in),
    .level(level1), .rise(rise1), .fall(fall1), .hold(hold1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_main(input string tag, input logic el, er, ef, eh);
    chk({tag, ".level"}, level, el);
    chk({tag, ".rise"},  rise,  er);
    chk({tag, ".fall"},  fall,  ef);
    chk({tag, ".hold"},  hold,  eh & HOLD_ON);
  endtask

  // Apply one sample, let one edge take it, then check both instances.
  task automatic step(input logic b, input logic el, er, ef, eh, input string tag);
    logic pm;
    bit_in = b;
    @(posedge clk);
    #1;
    pm = m1;
    m1 = b;
    if (!m1 || !pm) h1 = 0;
    else if (h1 < 8) h1++;
    chk_main(tag, el, er, ef, eh);
    chk({tag, ".l1"}, level1, m1);
    chk({tag, ".r1"}, rise1, m1 & !pm);
    chk({tag, ".f1"}, fall1, !m1 & pm);
    chk({tag, ".h1"}, hold1, HOLD_ON & (h1 == 8));
  endtask

  function automatic void add(input logic b, l, r, f, h);
    vec_t v;
    v.b = b; v.l = l; v.r = r; v.f = f; v.h = h;
    tv.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Clean press: flips on the 4th sampling edge, then hold count starts.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(1, 1, 0, 0, 0);
    // Release with bounce 0,1,0,0,0,0; hold reaches 8 on the bounce cycle.
    add(0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    // Glitch of 3 highs is rejected; a 4-high run flips with one rise.
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0);
    // Every-cycle toggling holds level; hold still matures after 8 cycles.
    for (int i = 0; i < 7; i++) add(logic'(i % 2), 1, 0, 0, 0);
    add(1, 1, 0, 0, 1);
    // Clean release: hold drops in the fall cycle.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0);

    // Reset held over a few edges.
    bit_in  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_main("in_reset", 0, 0, 0, 0);
    chk("in_reset.l1", level1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, $sformatf("idle%0d", i));

    foreach (tv[i]) step(tv[i].b, tv[i].l, tv[i].r, tv[i].f, tv[i].h, $sformatf("vec%0d", i));

    // Reset mid-confirm: partial count must be discarded.
    step(1, 0, 0, 0, 0, "mc0");
    step(1, 0, 0, 0, 0, "mc1");
    #2;
    reset_n = 1'b0;
    #1;
    m1 = 1'b0;
    h1 = 0;
    chk_main("mc_rst", 0, 0, 0, 0);
    chk("mc_rst.l1", level1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 0, 0, "mc2");
    step(1, 0, 0, 0, 0, "mc3");
    step(1, 0, 0, 0, 0, "mc4");
    step(1, 1, 1, 0, 0, "mc5");

    // Asynchronous assertion right after a flip kills level and strobe.
    #2;
    reset_n = 1'b0;
    #1;
    m1 = 1'b0;
    h1 = 0;
    chk_main("async_rst", 0, 0, 0, 0);
    chk("async_rst.l1", level1, 1'b0);
    chk("async_rst.r1", rise1, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0, "post0");
    step(0, 0, 0, 0, 0, "post1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
